// File: rtl/fifo_pipe_if.sv
// Valid/ready handshake bundle for fifo_pipe: upstream (_f) and downstream (_b) sides.
interface fifo_pipe_if #(
  parameter int L = 8
);
  logic         ready_f;
  logic         valid_f;
  logic [L-1:0] data_f;
  logic         ready_b;
  logic         valid_b;
  logic [L-1:0] data_b;

  // Environment side: drives upstream words and downstream acceptance.
  modport master (
    input  ready_f,
    output valid_f,
    output data_f,
    output ready_b,
    input  valid_b,
    input  data_b
  );

  // Buffer side.
  modport slave (
    output ready_f,
    input  valid_f,
    input  data_f,
    input  ready_b,
    output valid_b,
    output data_b
  );
endinterface

// File: rtl/fifo_pipe.sv
// Multi-entry first-word-fall-through elastic buffer for the valid/ready pipeline.
// ready_f depends only on registered occupancy (and rst), never on ready_b.
module fifo_pipe #(
  parameter int L        = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  fifo_pipe_if.slave                   bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [L-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake outputs and transfer qualifiers, all from registered state.
  always_comb begin
    bus.ready_f = (count != CW'(DEPTH)) && !rst;
    bus.valid_b = (count != '0);
    bus.data_b  = (count != '0) ? mem[rd_ptr] : '0;
    almost_full = (count >= CW'(AF_LEVEL));
    push        = bus.valid_f && bus.ready_f;
    pop         = (count != '0) && bus.ready_b;
  end

  // Storage write; contents need no reset since valid_b gates data_b.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_f;
    end
  end

  // Read/write pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pipe.sv
// Directed + random self-checking bench for fifo_pipe with a queue scoreboard.
module tb_fifo_pipe;

  localparam int L     = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count;
  logic       almost_full;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [L-1:0] q[$];
  logic         pend_pop;
  logic         pend_push;
  logic [L-1:0] pend_obs;
  logic [L-1:0] pend_din;

  fifo_pipe_if #(.L(L)) bus ();

  fifo_pipe #(
    .L(L),
    .DEPTH(DEPTH),
    .AF_LEVEL(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    int unsigned sz;
    logic        m_ready;
    logic        m_valid;
    @(negedge clk);
    sz      = q.size();
    m_valid = (sz != 0);
    m_ready = (sz != DEPTH) && !rst;
    chk("count", 32'(count), sz);
    chk("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
    chk("valid_b", 32'(bus.valid_b), 32'(m_valid));
    chk("ready_f", 32'(bus.ready_f), 32'(m_ready));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    if (!m_valid) chk("data_b_idle", 32'(bus.data_b), 32'd0);
    pend_pop  = m_valid && bus.ready_b && !rst;
    pend_push = bus.valid_f && m_ready;
    pend_obs  = bus.data_b;
    pend_din  = bus.data_f;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (pend_pop) chk("pop_data", 32'(pend_obs), 32'(q.pop_front()));
      if (pend_push) q.push_back(pend_din);
    end
    #1;
  endtask

  initial begin
    bus.valid_f = 1'b0;
    bus.data_f  = '0;
    bus.ready_b = 1'b0;

    // First reset edge: DUT state is unknown before it, so no check yet.
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid_b", 32'(bus.valid_b), 32'd0);
    chk("rst_data_b", 32'(bus.data_b), 32'd0);
    chk("rst_ready_f", 32'(bus.ready_f), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);

    // Fill with downstream stalled, then drain.
    bus.ready_b = 1'b0;
    bus.valid_f = 1'b1;
    bus.data_f = 8'h11; tick(); chk("fill_c1", 32'(count), 32'd1); chk("fill_af1", 32'(almost_full), 32'd0);
    bus.data_f = 8'h22; tick(); chk("fill_c2", 32'(count), 32'd2); chk("fill_af2", 32'(almost_full), 32'd0);
    bus.data_f = 8'h33; tick(); chk("fill_c3", 32'(count), 32'd3); chk("fill_af3", 32'(almost_full), 32'd1);
    bus.data_f = 8'h44; tick(); chk("fill_c4", 32'(count), 32'd4); chk("full_ready_f", 32'(bus.ready_f), 32'd0);
    bus.valid_f = 1'b0;
    chk("head_11", 32'(bus.data_b), 32'h11);
    bus.ready_b = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid_b", 32'(bus.valid_b), 32'd0);

    // Streaming: each word passes with one cycle latency, occupancy stays 1.
    bus.valid_f = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_f = 8'(i);
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_ready_f", 32'(bus.ready_f), 32'd1);
      chk("stream_head", 32'(bus.data_b), 32'(i));
    end
    bus.valid_f = 1'b0;
    tick();

    // Full with simultaneous pop: no push that cycle, AA accepted next cycle.
    bus.ready_b = 1'b0;
    bus.valid_f = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.data_f = 8'(i);
      tick();
    end
    bus.data_f  = 8'hAA;
    bus.ready_b = 1'b1;
    tick();
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_ready_f", 32'(bus.ready_f), 32'd1);
    bus.ready_b = 1'b0;
    tick();
    chk("fullpop_refill", 32'(count), 32'd4);
    bus.valid_f = 1'b0;
    bus.ready_b = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Stall stability: head held while pushes continue.
    bus.ready_b = 1'b0;
    bus.valid_f = 1'b1;
    bus.data_f  = 8'h5C;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.data_f = 8'(8'h60 + i);
      tick();
      chk("stall_data_b", 32'(bus.data_b), 32'h5C);
      chk("stall_valid_b", 32'(bus.valid_b), 32'd1);
    end
    bus.valid_f = 1'b0;
    bus.ready_b = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Random traffic across pointer wrap.
    for (int i = 0; i < 200; i++) begin
      bus.valid_f = 1'($urandom_range(0, 1));
      bus.ready_b = 1'($urandom_range(0, 1));
      bus.data_f  = 8'($urandom);
      tick();
    end
    bus.valid_f = 1'b0;
    bus.ready_b = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Mid-operation reset discards held words.
    bus.ready_b = 1'b0;
    bus.valid_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_f = 8'(8'hC0 + i);
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.valid_f = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid_b", 32'(bus.valid_b), 32'd0);
    chk("mid_rst_data_b", 32'(bus.data_b), 32'd0);
    chk("mid_rst_ready_f", 32'(bus.ready_f), 32'd1);
    chk("mid_rst_af", 32'(almost_full), 32'd0);
    bus.valid_f = 1'b1;
    bus.data_f  = 8'h77;
    tick();
    bus.valid_f = 1'b0;
    chk("post_rst_data_b", 32'(bus.data_b), 32'h77);
    chk("post_rst_valid_b", 32'(bus.valid_b), 32'd1);
    bus.ready_b = 1'b1;
    tick();
    tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
